mem_bus_arbiter: RTL and testbench

- Shares the single 16-bit memory bus between the processor core (primary master) and one secondary master: debug loader or DMA.
- Sits between `core` (ABUS/DBUS_OUT/DBUS_IN/RD/WR) and the memory/IO decode.
- Core has priority. The secondary master takes the bus only on core-idle cycles, e.g. DECODE.
- The core is stalled with CORE_STALL when it needs the bus while the secondary master owns it.

---
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the core and a secondary
// (debug/DMA) master. The core has priority; the secondary master is granted
// only on core-idle cycles, and the core is stalled while the secondary owns
// the bus.
//
// Optional build macro: ARB_EXT_BURST_LIMIT_EN. When it is defined, the number
// of stalled-core EXT accesses is capped at EXT_MAX_BURST, and a yield cycle
// is required before the secondary master can be granted again.
//
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   CORE_ABUS/DOUT/RD/WR -> MEM_*    core request, passed with zero latency
//   CORE_DIN, CORE_STALL             read data to the core, stall
//   EXT_REQ/ABUS/DOUT/RD/WR          secondary master request
//   EXT_GNT, EXT_ACK, EXT_DIN        grant, access acknowledge, read data
//   MEM_ABUS/DOUT/RD/WR, MEM_DIN     memory side of the bus
module mem_bus_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 16,
    parameter int EXT_MAX_BURST = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] CORE_ABUS,
    input  logic [DW-1:0] CORE_DOUT,
    input  logic          CORE_RD,
    input  logic          CORE_WR,
    output logic [DW-1:0] CORE_DIN,
    output logic          CORE_STALL,
    input  logic          EXT_REQ,
    output logic          EXT_GNT,
    input  logic [AW-1:0] EXT_ABUS,
    input  logic [DW-1:0] EXT_DOUT,
    input  logic          EXT_RD,
    input  logic          EXT_WR,
    output logic [DW-1:0] EXT_DIN,
    output logic          EXT_ACK,
    output logic [AW-1:0] MEM_ABUS,
    output logic [DW-1:0] MEM_DOUT,
    output logic          MEM_RD,
    output logic          MEM_WR,
    input  logic [DW-1:0] MEM_DIN
);

    // The burst counter is 4 bits wide, so the limit must fit in 1..15.
    if (EXT_MAX_BURST < 1 || EXT_MAX_BURST > 15) begin : g_bad_max_burst
        $error("EXT_MAX_BURST must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_CORE    = 2'd0,
        S_EXT     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_core_act;
    logic w_ext_act;
    logic w_stall;
    logic w_ack;
    logic w_force;
    logic w_yield_ok;

    assign w_core_act = CORE_RD | CORE_WR;
    assign w_ext_act  = EXT_RD | EXT_WR;

    // The read data is broadcast; the strobes decide who consumes it.
    assign CORE_DIN   = MEM_DIN;
    assign EXT_DIN    = MEM_DIN;
    assign EXT_ACK    = w_ack;
    assign CORE_STALL = w_stall;

`ifdef ARB_EXT_BURST_LIMIT_EN
    localparam logic [3:0] LP_MAX = 4'(EXT_MAX_BURST);

    logic [3:0] r_cnt;
    logic       r_yield;

    // Release on the cycle that performs the last allowed stalled access.
    assign w_force = (r_state == S_EXT) && w_stall && w_ack &&
                     (r_cnt == LP_MAX - 4'd1);
    assign w_yield_ok = !r_yield;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_EXT && w_stall) begin
            if (w_ack && r_cnt != LP_MAX) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end else begin
            r_cnt <= 4'd0;
        end
    end

    // After a forced release, EXT must wait until the core has used the bus
    // or EXT itself has let go of its request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_yield <= 1'b0;
        end else if (w_force) begin
            r_yield <= 1'b1;
        end else if (r_state == S_CORE && (w_core_act || !EXT_REQ)) begin
            r_yield <= 1'b0;
        end
    end
`else
    assign w_force    = 1'b0;
    assign w_yield_ok = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_CORE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_CORE: begin
                if (EXT_REQ && !w_core_act && w_yield_ok) begin
                    w_next = S_EXT;
                end
            end
            S_EXT: begin
                if (!EXT_REQ || w_force) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: w_next = S_CORE;
            default:   w_next = S_CORE;
        endcase
    end

    // Bus mux: the core path is the default so it adds no latency.
    always_comb begin
        MEM_ABUS = CORE_ABUS;
        MEM_DOUT = CORE_DOUT;
        MEM_RD   = CORE_RD;
        MEM_WR   = CORE_WR;
        EXT_GNT  = 1'b0;
        w_ack    = 1'b0;
        w_stall  = 1'b0;
        if (RESET) begin
            MEM_RD = 1'b0;
            MEM_WR = 1'b0;
        end else begin
            unique case (r_state)
                S_EXT: begin
                    MEM_ABUS = EXT_ABUS;
                    MEM_DOUT = EXT_DOUT;
                    MEM_RD   = EXT_RD;
                    MEM_WR   = EXT_WR;
                    EXT_GNT  = 1'b1;
                    w_ack    = w_ext_act;
                    w_stall  = w_core_act;
                end
                S_RELEASE: begin
                    MEM_RD  = 1'b0;
                    MEM_WR  = 1'b0;
                    w_stall = w_core_act;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a bus-ownership model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int MAXB = 8;
    localparam int OWN_CORE = 0;
    localparam int OWN_EXT  = 1;
    localparam int OWN_GAP  = 2;

    logic        clk;
    logic        rst;
    logic [15:0] core_abus, core_dout, core_din;
    logic        core_rd, core_wr, core_stall;
    logic        ext_req, ext_gnt, ext_rd, ext_wr, ext_ack;
    logic [15:0] ext_abus, ext_dout, ext_din;
    logic [15:0] mem_abus, mem_dout, mem_din;
    logic        mem_rd, mem_wr;

    int n_checks = 0;
    int n_fail   = 0;

    int m_own   = OWN_CORE;
    int m_run   = 0;
    bit m_yield = 1'b0;
    bit m_stall = 1'b0;

    logic [15:0] obs_din, obs_abus;
    logic        obs_gnt, obs_ack, obs_stall, obs_rd, obs_wr;

    mem_bus_arbiter #(
        .AW(16), .DW(16), .EXT_MAX_BURST(MAXB)
    ) dut (
        .CLK(clk), .RESET(rst),
        .CORE_ABUS(core_abus), .CORE_DOUT(core_dout),
        .CORE_RD(core_rd), .CORE_WR(core_wr),
        .CORE_DIN(core_din), .CORE_STALL(core_stall),
        .EXT_REQ(ext_req), .EXT_GNT(ext_gnt),
        .EXT_ABUS(ext_abus), .EXT_DOUT(ext_dout),
        .EXT_RD(ext_rd), .EXT_WR(ext_wr),
        .EXT_DIN(ext_din), .EXT_ACK(ext_ack),
        .MEM_ABUS(mem_abus), .MEM_DOUT(mem_dout),
        .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_DIN(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: sample mid-cycle, compare, then advance the model.
    task automatic tick();
        logic [15:0] e_a, e_d;
        logic        e_rd, e_wr, e_gnt, e_ack, e_stl;
        #3;
        e_a   = core_abus;
        e_d   = core_dout;
        e_rd  = core_rd;
        e_wr  = core_wr;
        e_gnt = 1'b0;
        e_ack = 1'b0;
        e_stl = 1'b0;
        if (rst) begin
            e_rd = 1'b0;
            e_wr = 1'b0;
        end else if (m_own == OWN_EXT) begin
            e_a   = ext_abus;
            e_d   = ext_dout;
            e_rd  = ext_rd;
            e_wr  = ext_wr;
            e_gnt = 1'b1;
            e_ack = ext_rd | ext_wr;
            e_stl = core_rd | core_wr;
        end else if (m_own == OWN_GAP) begin
            e_rd  = 1'b0;
            e_wr  = 1'b0;
            e_stl = core_rd | core_wr;
        end
        if (rst || m_own != OWN_GAP) begin
            chk("mem_abus", 32'(mem_abus), 32'(e_a));
            chk("mem_dout", 32'(mem_dout), 32'(e_d));
        end
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("ext_gnt", 32'(ext_gnt), 32'(e_gnt));
        chk("ext_ack", 32'(ext_ack), 32'(e_ack));
        chk("core_stall", 32'(core_stall), 32'(e_stl));
        chk("core_din", 32'(core_din), 32'(mem_din));
        chk("ext_din", 32'(ext_din), 32'(mem_din));
        obs_din   = core_din;
        obs_abus  = mem_abus;
        obs_gnt   = ext_gnt;
        obs_ack   = ext_ack;
        obs_stall = core_stall;
        obs_rd    = mem_rd;
        obs_wr    = mem_wr;
        m_stall   = e_stl;
        @(posedge clk);
        if (rst) begin
            m_own   = OWN_CORE;
            m_run   = 0;
            m_yield = 1'b0;
        end else if (m_own == OWN_CORE) begin
            if (ext_req && !(core_rd | core_wr) && !m_yield) begin
                m_own = OWN_EXT;
                m_run = 0;
            end
            if ((core_rd | core_wr) || !ext_req) m_yield = 1'b0;
        end else if (m_own == OWN_EXT) begin
            if (!ext_req) m_own = OWN_GAP;
`ifdef ARB_EXT_BURST_LIMIT_EN
            if (core_rd | core_wr) begin
                if (ext_rd | ext_wr) begin
                    m_run++;
                    if (m_run >= MAXB) begin
                        m_own   = OWN_GAP;
                        m_yield = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
`endif
        end else begin
            m_own = OWN_CORE;
        end
        #1;
    endtask

    task automatic idle_all();
        core_rd = 1'b0;
        core_wr = 1'b0;
        ext_req = 1'b0;
        ext_rd  = 1'b0;
        ext_wr  = 1'b0;
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        core_abus = 16'h0;
        core_dout = 16'h0;
        ext_abus  = 16'h0;
        ext_dout  = 16'h0;
        mem_din   = 16'h0;
        idle_all();
        core_rd = 1'b1;
        ext_req = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("rst_gnt", 32'(obs_gnt), 32'd0);
        chk("rst_rd", 32'(obs_rd), 32'd0);
        tick();
        rst = 1'b0;
        idle_all();

        // core read with zero latency
        core_rd   = 1'b1;
        core_abus = 16'h0100;
        mem_din   = 16'hBEEF;
        tick();
        chk("t1_rd", 32'(obs_rd), 32'd1);
        chk("t1_abus", 32'(obs_abus), 32'h0100);
        chk("t1_din", 32'(obs_din), 32'hBEEF);
        chk("t1_stall", 32'(obs_stall), 32'd0);

        // EXT request waits for a core-idle cycle
        ext_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_busy_gnt", 32'(obs_gnt), 32'd0);
        end
        core_rd = 1'b0;
        tick();
        chk("t2_idle_gnt", 32'(obs_gnt), 32'd0);

        // granted EXT write, request dropped in the same cycle
        ext_wr   = 1'b1;
        ext_abus = 16'h2000;
        ext_dout = 16'h1234;
        ext_req  = 1'b0;
        tick();
        chk("t3_gnt", 32'(obs_gnt), 32'd1);
        chk("t3_wr", 32'(obs_wr), 32'd1);
        chk("t3_ack", 32'(obs_ack), 32'd1);
        chk("t3_abus", 32'(obs_abus), 32'h2000);
        ext_wr = 1'b0;
        tick();
        chk("t3_gap_wr", 32'(obs_wr), 32'd0);
        chk("t3_gap_gnt", 32'(obs_gnt), 32'd0);
        tick();

        // core stalled during EXT tenure, then served unchanged
        ext_req = 1'b1;
        tick();
        core_rd   = 1'b1;
        core_abus = 16'h0300;
        ext_rd    = 1'b1;
        ext_abus  = 16'h4000;
        tick();
        chk("t4_stall_ext", 32'(obs_stall), 32'd1);
        ext_req = 1'b0;
        ext_rd  = 1'b0;
        tick();
        chk("t4_stall_ext2", 32'(obs_stall), 32'd1);
        tick();
        chk("t4_stall_gap", 32'(obs_stall), 32'd1);
        chk("t4_gap_rd", 32'(obs_rd), 32'd0);
        tick();
        chk("t4_stall_core", 32'(obs_stall), 32'd0);
        chk("t4_rd", 32'(obs_rd), 32'd1);
        chk("t4_abus", 32'(obs_abus), 32'h0300);

        // reset while EXT owns the bus
        idle_all();
        ext_req = 1'b1;
        tick();
        tick();
        chk("t6_pre_gnt", 32'(obs_gnt), 32'd1);
        rst       = 1'b1;
        core_rd   = 1'b1;
        core_abus = 16'h0500;
        tick();
        chk("t6_rst_rd", 32'(obs_rd), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_gnt", 32'(obs_gnt), 32'd0);
        chk("t6_stall", 32'(obs_stall), 32'd0);
        chk("t6_abus", 32'(obs_abus), 32'h0500);

        // EXT streams reads against a stalled core
        idle_all();
        tick();
        ext_req = 1'b1;
        tick();
        core_rd = 1'b1;
        ext_rd  = 1'b1;
        acks    = 0;
        for (int i = 0; i < 20; i++) begin
            ext_abus = 16'($urandom);
            tick();
            if (obs_ack) acks++;
        end
`ifdef ARB_EXT_BURST_LIMIT_EN
        chk("t5_acks", 32'(acks), 32'(MAXB));
        chk("t5_core_rd", 32'(obs_rd), 32'd1);
        chk("t5_core_abus", 32'(obs_abus), 32'(core_abus));
        core_rd = 1'b0;
        tick();
        chk("t5_idle_gnt", 32'(obs_gnt), 32'd0);
        tick();
        chk("t5_regnt", 32'(obs_gnt), 32'd1);
`else
        chk("t5_acks", 32'(acks), 32'd20);
`endif

        // randomized traffic; the core holds its request while stalled
        idle_all();
        tick();
        for (int i = 0; i < 2000; i++) begin
            int c;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) ext_req = ~ext_req;
            if (!m_stall) begin
                c = $urandom_range(0, 3);
                core_rd   = (c == 1);
                core_wr   = (c == 2);
                core_abus = 16'($urandom);
                core_dout = 16'($urandom);
            end
            c = $urandom_range(0, 2);
            ext_rd   = (c == 1);
            ext_wr   = (c == 2);
            ext_abus = 16'($urandom);
            ext_dout = 16'($urandom);
            mem_din  = 16'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
